// File: rtl/fp_mul_pkg.sv
// -----------------------------------------------------------------------------
// fp_mul_pkg
// Shared types, constants and helper functions for the pipelined FP multiplier.
//   fp_class_e    : operand classification (ZERO/NORM/INF/NAN)
//   fp_bias()     : exponent bias from exponent width
//   fp_width()    : packed word width from exponent/mantissa widths
//   fp_canon_nan(): canonical quiet NaN bit pattern (sign 0, quiet bit set)
//   STAT_*        : bit positions inside the optional status vector
// Optional feature macro: FP_MUL_STATUS_EN (status port, see fp_multiply_pipe).
// -----------------------------------------------------------------------------
package fp_mul_pkg;

    typedef enum logic [1:0] {
        CLS_ZERO = 2'd0,
        CLS_NORM = 2'd1,
        CLS_INF  = 2'd2,
        CLS_NAN  = 2'd3
    } fp_class_e;

    localparam int unsigned STAT_W         = 4;
    localparam int unsigned STAT_INVALID   = 3;
    localparam int unsigned STAT_OVERFLOW  = 2;
    localparam int unsigned STAT_UNDERFLOW = 1;
    localparam int unsigned STAT_INEXACT   = 0;

    function automatic int unsigned fp_bias(input int unsigned exp_w);
        return (32'd1 << (exp_w - 32'd1)) - 32'd1;
    endfunction

    function automatic int unsigned fp_width(input int unsigned exp_w, input int unsigned man_w);
        return 32'd1 + exp_w + man_w;
    endfunction

    // Exponent all-ones, fraction MSB set, everything else zero.
    function automatic logic [63:0] fp_canon_nan(input int unsigned exp_w, input int unsigned man_w);
        return (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 32'd1));
    endfunction

endpackage

// File: rtl/fp_multiply_pipe_if.sv
// -----------------------------------------------------------------------------
// fp_multiply_pipe_if
// Operand/result bus for fp_multiply_pipe.
//   in_valid/in_ready       : operand handshake
//   operand_1/operand_2     : {sign, exp, frac} operands, W bits
//   out_valid/out_ready     : result handshake
//   result                  : {sign, exp, frac} product, W bits
//   status (FP_MUL_STATUS_EN): {invalid, overflow, underflow, inexact}
// Modports: master = producer/consumer side, slave = multiplier side.
// -----------------------------------------------------------------------------
interface fp_multiply_pipe_if #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
);
    import fp_mul_pkg::*;

    localparam int unsigned W = fp_width(EXP_W, MAN_W);

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] operand_1;
    logic [W-1:0] operand_2;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;

`ifdef FP_MUL_STATUS_EN
    logic [STAT_W-1:0] status;

    modport master (
        output in_valid, operand_1, operand_2, out_ready,
        input  in_ready, out_valid, result, status
    );
    modport slave (
        input  in_valid, operand_1, operand_2, out_ready,
        output in_ready, out_valid, result, status
    );
`else
    modport master (
        output in_valid, operand_1, operand_2, out_ready,
        input  in_ready, out_valid, result
    );
    modport slave (
        input  in_valid, operand_1, operand_2, out_ready,
        output in_ready, out_valid, result
    );
`endif

endinterface

// File: rtl/fp_mul_round.sv
// -----------------------------------------------------------------------------
// fp_mul_round
// Combinational round-to-nearest, ties-to-even on a normalised significand.
//   i_frac    : fraction bits (hidden one excluded)
//   i_guard   : first bit below the fraction LSB
//   i_round   : second bit below the fraction LSB
//   i_sticky  : OR of all remaining lower bits
//   o_frac_c  : rounded fraction
//   o_carry_c : fraction overflowed to 1.0 (caller bumps the exponent)
// -----------------------------------------------------------------------------
module fp_mul_round #(
    parameter int unsigned MAN_W = 23
) (
    input  logic [MAN_W-1:0] i_frac,
    input  logic             i_guard,
    input  logic             i_round,
    input  logic             i_sticky,
    output logic [MAN_W-1:0] o_frac_c,
    output logic             o_carry_c
);
    logic w_up;

    // Above half-ulp rounds up; exactly half rounds up only when LSB is odd.
    assign w_up = i_guard & (i_round | i_sticky | i_frac[0]);
    assign {o_carry_c, o_frac_c} = {1'b0, i_frac} + (MAN_W + 1)'(w_up);

endmodule

// File: rtl/fp_multiply_pipe.sv
// -----------------------------------------------------------------------------
// fp_multiply_pipe
// 3-stage pipelined floating-point multiplier with valid/ready flow control,
// round-to-nearest-even, flush-to-zero and full special-case handling.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : fp_multiply_pipe_if.slave (operands in, result out)
// Stages: S1 unpack/classify/multiply, S2 normalise/round, S3 special select.
// Global stall: the whole pipe advances when S3 is empty or being drained.
// Optional feature macro: FP_MUL_STATUS_EN adds bus.status.
// -----------------------------------------------------------------------------
module fp_multiply_pipe
    import fp_mul_pkg::*;
#(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic                  clk,
    input  logic                  rst,
    fp_multiply_pipe_if.slave     bus
);
    localparam int unsigned W    = fp_width(EXP_W, MAN_W);
    localparam int unsigned EW   = EXP_W + 2;
    localparam int unsigned PW   = 2 * (MAN_W + 1);
    localparam int unsigned BIAS = fp_bias(EXP_W);
    localparam logic signed [EW-1:0] EXP_MAX  = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] EXP_ZERO = '0;
    localparam logic [W-1:0] CANON_NAN = W'(fp_canon_nan(EXP_W, MAN_W));

    function automatic fp_class_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
        if (e == '0)          return CLS_ZERO;
        else if (&e)          return (f == '0) ? CLS_INF : CLS_NAN;
        else                  return CLS_NORM;
    endfunction

    // ---------------- pipeline registers ----------------
    logic                 r_s1_valid, r_s2_valid, r_s3_valid;
    logic                 r_s1_sign, r_s2_sign;
    fp_class_e            r_s1_cls1, r_s1_cls2, r_s2_cls1, r_s2_cls2;
    logic signed [EW-1:0] r_s1_exp, r_s2_exp;
    logic [PW-1:0]        r_s1_prod;
    logic [MAN_W-1:0]     r_s2_frac;
    logic [W-1:0]         r_s3_result;
`ifdef FP_MUL_STATUS_EN
    logic                 r_s1_sub, r_s2_sub, r_s2_rnd;
    logic [STAT_W-1:0]    r_s3_status;
`endif

    logic w_advance;
    assign w_advance    = !r_s3_valid || bus.out_ready;
    assign bus.in_ready = w_advance;

    // ---------------- S1: unpack, classify, exponent sum, significand product ----------------
    logic [EXP_W-1:0] w_e1, w_e2;
    logic [MAN_W-1:0] w_f1, w_f2;
    logic [PW-1:0]    w_prod;
    assign w_e1   = bus.operand_1[W-2 -: EXP_W];
    assign w_e2   = bus.operand_2[W-2 -: EXP_W];
    assign w_f1   = bus.operand_1[MAN_W-1:0];
    assign w_f2   = bus.operand_2[MAN_W-1:0];
    assign w_prod = PW'({1'b1, w_f1}) * PW'({1'b1, w_f2});

    // ---------------- S2: normalise and round ----------------
    logic                 w_msb, w_carry;
    logic [PW-2:0]        w_norm;
    logic [MAN_W-1:0]     w_frac_rnd;
    logic                 w_g, w_r, w_s;
    logic signed [EW-1:0] w_s2_exp;

    // Align so the leading one sits just above bit PW-2 (dropped as hidden bit).
    assign w_msb  = r_s1_prod[PW-1];
    assign w_norm = w_msb ? r_s1_prod[PW-2:0] : {r_s1_prod[PW-3:0], 1'b0};
    assign w_g    = w_norm[MAN_W];
    assign w_r    = w_norm[MAN_W-1];
    assign w_s    = |w_norm[MAN_W-2:0];

    fp_mul_round #(.MAN_W(MAN_W)) u_round (
        .i_frac    (w_norm[PW-2 -: MAN_W]),
        .i_guard   (w_g),
        .i_round   (w_r),
        .i_sticky  (w_s),
        .o_frac_c  (w_frac_rnd),
        .o_carry_c (w_carry)
    );

    assign w_s2_exp = r_s1_exp + EW'(w_msb) + EW'(w_carry);

    // ---------------- S3: special-case select ----------------
    logic         w_nan, w_inf, w_zero, w_special, w_ovf, w_unf;
    logic [W-1:0] w_result;
    always_comb begin
        w_nan     = (r_s2_cls1 == CLS_NAN) || (r_s2_cls2 == CLS_NAN) ||
                    ((r_s2_cls1 == CLS_INF) && (r_s2_cls2 == CLS_ZERO)) ||
                    ((r_s2_cls1 == CLS_ZERO) && (r_s2_cls2 == CLS_INF));
        w_inf     = (r_s2_cls1 == CLS_INF) || (r_s2_cls2 == CLS_INF);
        w_zero    = (r_s2_cls1 == CLS_ZERO) || (r_s2_cls2 == CLS_ZERO);
        w_special = w_nan || w_inf || w_zero;
        w_ovf     = !w_special && (r_s2_exp >= EXP_MAX);
        w_unf     = !w_special && !w_ovf && (r_s2_exp <= EXP_ZERO);
        w_result  = {r_s2_sign, r_s2_exp[EXP_W-1:0], r_s2_frac};
        if (w_nan)
            w_result = CANON_NAN;
        else if (w_inf || w_ovf)
            w_result = {r_s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else if (w_zero || w_unf)
            w_result = {r_s2_sign, {(W-1){1'b0}}};
    end

`ifdef FP_MUL_STATUS_EN
    logic [STAT_W-1:0] w_status;
    always_comb begin
        w_status                 = '0;
        w_status[STAT_INVALID]   = w_nan;
        w_status[STAT_OVERFLOW]  = w_ovf;
        w_status[STAT_UNDERFLOW] = w_unf || r_s2_sub;
        w_status[STAT_INEXACT]   = w_ovf || w_unf || r_s2_sub || (!w_special && r_s2_rnd);
    end
`endif

    // ---------------- stage registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s2_valid  <= 1'b0;
            r_s3_valid  <= 1'b0;
            r_s1_sign   <= 1'b0;
            r_s2_sign   <= 1'b0;
            r_s1_cls1   <= CLS_ZERO;
            r_s1_cls2   <= CLS_ZERO;
            r_s2_cls1   <= CLS_ZERO;
            r_s2_cls2   <= CLS_ZERO;
            r_s1_exp    <= '0;
            r_s2_exp    <= '0;
            r_s1_prod   <= '0;
            r_s2_frac   <= '0;
            r_s3_result <= '0;
`ifdef FP_MUL_STATUS_EN
            r_s1_sub    <= 1'b0;
            r_s2_sub    <= 1'b0;
            r_s2_rnd    <= 1'b0;
            r_s3_status <= '0;
`endif
        end else if (w_advance) begin
            r_s1_valid <= bus.in_valid;
            r_s1_sign  <= bus.operand_1[W-1] ^ bus.operand_2[W-1];
            r_s1_cls1  <= classify(w_e1, w_f1);
            r_s1_cls2  <= classify(w_e2, w_f2);
            r_s1_exp   <= EW'(w_e1) + EW'(w_e2) - EW'(BIAS);
            r_s1_prod  <= w_prod;

            r_s2_valid <= r_s1_valid;
            r_s2_sign  <= r_s1_sign;
            r_s2_cls1  <= r_s1_cls1;
            r_s2_cls2  <= r_s1_cls2;
            r_s2_exp   <= w_s2_exp;
            r_s2_frac  <= w_frac_rnd;

            r_s3_valid <= r_s2_valid;
            // Bubbles leave the last result in place.
            if (r_s2_valid)
                r_s3_result <= w_result;
`ifdef FP_MUL_STATUS_EN
            r_s1_sub <= ((w_e1 == '0) && (w_f1 != '0)) || ((w_e2 == '0) && (w_f2 != '0));
            r_s2_sub <= r_s1_sub;
            r_s2_rnd <= w_g | w_r | w_s;
            if (r_s2_valid)
                r_s3_status <= w_status;
`endif
        end
    end

    assign bus.out_valid = r_s3_valid;
    assign bus.result    = r_s3_result;
`ifdef FP_MUL_STATUS_EN
    assign bus.status    = r_s3_status;
`endif

endmodule

// File: tb/tb_fp_multiply_pipe.sv
// -----------------------------------------------------------------------------
// tb_fp_multiply_pipe
// Directed self-checking bench for fp_multiply_pipe (EXP_W=8, MAN_W=23).
// Inputs are driven and outputs sampled around the falling clock edge.
// Honours FP_MUL_STATUS_EN when the design is built with it.
// -----------------------------------------------------------------------------
module tb_fp_multiply_pipe;
    import fp_mul_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fp_multiply_pipe_if #(.EXP_W(8), .MAN_W(23)) bus_if ();

    fp_multiply_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  stat;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    int n_checks = 0;
    int n_errors = 0;
    int cyc, acc, got, first, last, seen;
    logic rdy, ov, drv;
    logic [31:0] res;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp_v);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //             a             b             result        {inv,ovf,unf,inx}
        vecs[0]  = '{32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000};
        vecs[1]  = '{32'hBF800000, 32'h40400000, 32'hC0400000, 4'b0000};
        vecs[2]  = '{32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0001};
        vecs[3]  = '{32'h3FC00000, 32'h3FC00000, 32'h40100000, 4'b0000};
        vecs[4]  = '{32'h3F800001, 32'h3FFFFFFE, 32'h40000000, 4'b0001};
        vecs[5]  = '{32'h40000000, 32'h40400000, 32'h40C00000, 4'b0000};
        vecs[6]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000};
        vecs[7]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000};
        vecs[8]  = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b1000};
        vecs[9]  = '{32'h80000000, 32'h3F800000, 32'h80000000, 4'b0000};
        vecs[10] = '{32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 4'b0101};
        vecs[11] = '{32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011};

        rst              = 1'b1;
        bus_if.in_valid  = 1'b0;
        bus_if.operand_1 = '0;
        bus_if.operand_2 = '0;
        bus_if.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_out_valid", 32'(bus_if.out_valid), 32'd0);
        check("reset_result", bus_if.result, 32'd0);
        check("reset_in_ready", 32'(bus_if.in_ready), 32'd1);
        rst = 1'b0;

        // Single ops: latency, value and flags
        for (int i = 0; i < NV; i++) begin
            check($sformatf("in_ready[%0d]", i), 32'(bus_if.in_ready), 32'd1);
            bus_if.in_valid  = 1'b1;
            bus_if.operand_1 = vecs[i].a;
            bus_if.operand_2 = vecs[i].b;
            @(negedge clk);
            bus_if.in_valid = 1'b0;
            cyc = 1;
            while (!bus_if.out_valid && cyc < 10) begin
                @(negedge clk);
                cyc++;
            end
            check($sformatf("latency[%0d]", i), 32'(cyc), 32'd3);
            check($sformatf("result[%0d]", i), bus_if.result, vecs[i].res);
`ifdef FP_MUL_STATUS_EN
            check($sformatf("status[%0d]", i), 32'(bus_if.status), 32'(vecs[i].stat));
`endif
        end
        @(negedge clk);

        // Back-pressure: consumer stalled, producer streams 5 ops
        bus_if.out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 7; c++) begin
            drv = (acc < 5);
            bus_if.in_valid = drv;
            if (drv) begin
                bus_if.operand_1 = vecs[acc].a;
                bus_if.operand_2 = vecs[acc].b;
            end
            #1;
            rdy = bus_if.in_ready;
            @(negedge clk);
            if (drv && rdy) acc++;
        end
        check("bp_accepted", 32'(acc), 32'd3);
        check("bp_in_ready_low", 32'(bus_if.in_ready), 32'd0);
        check("bp_out_valid", 32'(bus_if.out_valid), 32'd1);
        check("bp_result_held", bus_if.result, vecs[0].res);

        // Release: remaining ops enter, all five leave in order back-to-back
        bus_if.out_ready = 1'b1;
        got   = 0;
        first = -1;
        last  = -1;
        for (int c = 0; c < 20 && got < 5; c++) begin
            drv = (acc < 5);
            bus_if.in_valid = drv;
            if (drv) begin
                bus_if.operand_1 = vecs[acc].a;
                bus_if.operand_2 = vecs[acc].b;
            end
            #1;
            rdy = bus_if.in_ready;
            ov  = bus_if.out_valid;
            res = bus_if.result;
            if (ov) begin
                check($sformatf("bp_order[%0d]", got), res, vecs[got].res);
                if (got == 0) first = c;
                last = c;
                got++;
            end
            @(negedge clk);
            if (drv && rdy) acc++;
        end
        bus_if.in_valid = 1'b0;
        check("bp_drained", 32'(got), 32'd5);
        check("bp_span", 32'(last - first), 32'd4);
        @(negedge clk);

        // Reset with two ops in flight
        for (int k = 5; k < 7; k++) begin
            bus_if.in_valid  = 1'b1;
            bus_if.operand_1 = vecs[k].a;
            bus_if.operand_2 = vecs[k].b;
            @(negedge clk);
        end
        bus_if.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_out_valid", 32'(bus_if.out_valid), 32'd0);
        check("mid_rst_result", bus_if.result, 32'd0);
        check("mid_rst_in_ready", 32'(bus_if.in_ready), 32'd1);
        rst  = 1'b0;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus_if.out_valid) seen++;
        end
        check("post_rst_no_stale", 32'(seen), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
